// File: rtl/regfile_sweep.sv
// 32-entry RV32I integer register file: two async read ports and one sync write port, with x0 hardwired to zero.
// After reset, a sweep FSM clears entries 1..N-1 before Ready rises; reads return 0 until then, and the optional bypass forwards write data.
module regfile_sweep #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  REGFILE_Clk,
  input  logic                  REGFILE_Reset_InLow,
  input  logic                  REGFILE_Write,
  input  logic [ADDR_WIDTH-1:0] REGFILE_WriteAddr,
  input  logic [DATA_WIDTH-1:0] REGFILE_WriteData,
  input  logic [ADDR_WIDTH-1:0] REGFILE_ReadAddr1,
  input  logic [ADDR_WIDTH-1:0] REGFILE_ReadAddr2,
  output logic [DATA_WIDTH-1:0] REGFILE_ReadData1,
  output logic [DATA_WIDTH-1:0] REGFILE_ReadData2,
  output logic                  REGFILE_Ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q = INIT;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;
  logic                  ready_q = 1'b0;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  wr_live;

  always_ff @(posedge REGFILE_Clk) begin
    if (!REGFILE_Reset_InLow) begin
      state_q <= INIT;
      ptr_q   <= ADDR_WIDTH'(1);
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == INIT) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
      if (ptr_q == {ADDR_WIDTH{1'b1}}) state_d = RUN;
    end
  end

  // The sweep owns the write port during INIT, so host writes are dropped rather than queued.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = '0;
    if (REGFILE_Reset_InLow) begin
      case (state_q)
        INIT: mem_we = 1'b1;
        RUN: begin
          mem_we    = wr_live;
          mem_waddr = REGFILE_WriteAddr;
          mem_wdata = REGFILE_WriteData;
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge REGFILE_Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign wr_live       = REGFILE_Write && (REGFILE_WriteAddr != '0);
  assign REGFILE_Ready = ready_q;

  // Gating on ready_q keeps uninitialised storage off the read ports, even before the first reset.
  always_comb begin
    REGFILE_ReadData1 = '0;
    if (ready_q && REGFILE_ReadAddr1 != '0) begin
      if (BYPASS && wr_live && REGFILE_ReadAddr1 == REGFILE_WriteAddr)
        REGFILE_ReadData1 = REGFILE_WriteData;
      else
        REGFILE_ReadData1 = mem[REGFILE_ReadAddr1];
    end
  end

  always_comb begin
    REGFILE_ReadData2 = '0;
    if (ready_q && REGFILE_ReadAddr2 != '0) begin
      if (BYPASS && wr_live && REGFILE_ReadAddr2 == REGFILE_WriteAddr)
        REGFILE_ReadData2 = REGFILE_WriteData;
      else
        REGFILE_ReadData2 = mem[REGFILE_ReadAddr2];
    end
  end

endmodule

// File: tb/tb_regfile_sweep.sv
// Bench for regfile_sweep: runs bypass and non-bypass instances on shared stimulus, checks every cycle against a behavioural model,
// and uses directed vectors with literal expectations to pin the model itself.
module tb_regfile_sweep;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        rdy_b, rdy_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_sweep #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) u_byp (
    .REGFILE_Clk(clk), .REGFILE_Reset_InLow(rst_n), .REGFILE_Write(wr),
    .REGFILE_WriteAddr(wa), .REGFILE_WriteData(wd),
    .REGFILE_ReadAddr1(ra1), .REGFILE_ReadAddr2(ra2),
    .REGFILE_ReadData1(rd1_b), .REGFILE_ReadData2(rd2_b), .REGFILE_Ready(rdy_b)
  );

  regfile_sweep #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) u_nob (
    .REGFILE_Clk(clk), .REGFILE_Reset_InLow(rst_n), .REGFILE_Write(wr),
    .REGFILE_WriteAddr(wa), .REGFILE_WriteData(wd),
    .REGFILE_ReadAddr1(ra1), .REGFILE_ReadAddr2(ra2),
    .REGFILE_ReadData1(rd1_n), .REGFILE_ReadData2(rd2_n), .REGFILE_Ready(rdy_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the file is unusable for 31 edges after reset release, then holds all zeros.
  logic [31:0] m_mem [32];
  bit          m_ready = 1'b0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt   = 0;
      m_ready = 1'b0;
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == 31) begin
        m_ready = 1'b1;
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
      end
    end else if (wr && wa != 5'd0) begin
      m_mem[wa] = wd;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] addr, input bit byp);
    if (!m_ready || addr == 5'd0) return '0;
    if (byp && wr && wa != 5'd0 && wa == addr) return wd;
    return m_mem[addr];
  endfunction

  always @(negedge clk) begin
    chk("rdy_b", {31'd0, rdy_b}, {31'd0, m_ready});
    chk("rdy_n", {31'd0, rdy_n}, {31'd0, m_ready});
    chk("rd1_b", rd1_b, exp_rd(ra1, 1'b1));
    chk("rd2_b", rd2_b, exp_rd(ra2, 1'b1));
    chk("rd1_n", rd1_n, exp_rd(ra1, 1'b0));
    chk("rd2_n", rd2_n, exp_rd(ra2, 1'b0));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_check(input string name);
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk(name, {31'd0, rdy_b}, (i == 31) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    #1;
    chk("pre_reset_ready", {31'd0, rdy_b}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    ra1 = 5'd3; ra2 = 5'd31;
    // Write attempted on sweep edge 10 must be dropped; reads stay 0 throughout INIT.
    for (int i = 1; i <= 31; i++) begin
      if (i == 10) begin wr = 1'b1; wa = 5'd3; wd = 32'hABCD0000; end
      tick();
      wr = 1'b0;
      chk("init_ready", {31'd0, rdy_b}, (i == 31) ? 32'd1 : 32'd0);
      if (i < 31) chk("init_rd", rd1_b | rd2_b | rd1_n | rd2_n, 32'd0);
    end
    #1 chk("x3_dropped", rd1_b, 32'd0);

    // Fill every register with junk, then reset and confirm the sweep clears it.
    for (int i = 1; i <= 31; i++) begin
      wr = 1'b1; wa = 5'(i); wd = 32'hDEADBEEF ^ i;
      tick();
      wr = 1'b0;
      tick();
    end
    ra1 = 5'd17; #1 chk("fill_x17", rd1_n, 32'hDEADBEFE);
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    sweep_check("sweep_ready");
    for (int i = 1; i <= 31; i++) begin
      ra1 = 5'(i); ra2 = 5'(32 - i);
      #1;
      chk("swept_rd1", rd1_b, 32'd0);
      chk("swept_rd2", rd2_n, 32'd0);
    end

    // Basic write/read.
    wr = 1'b1; wa = 5'd5; wd = 32'h12345678;
    tick(); wr = 1'b0;
    ra1 = 5'd5; ra2 = 5'd6; #1;
    chk("basic_x5", rd1_b, 32'h12345678);
    chk("basic_x6", rd2_b, 32'd0);
    tick();

    // x0 hardwired.
    ra1 = 5'd0; ra2 = 5'd0; wr = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; #1;
    chk("x0_before", rd1_b | rd2_b, 32'd0);
    tick(); wr = 1'b0; #1;
    chk("x0_after", rd1_n | rd2_n, 32'd0);
    tick();

    // Bypass vs. no-bypass.
    wr = 1'b1; wa = 5'd7; wd = 32'h11111111; tick(); wr = 1'b0; tick();
    wr = 1'b1; wa = 5'd7; wd = 32'h22222222; ra1 = 5'd7; ra2 = 5'd7; #1;
    chk("byp_rd1", rd1_b, 32'h22222222);
    chk("byp_rd2", rd2_b, 32'h22222222);
    chk("nob_rd1_pre", rd1_n, 32'h11111111);
    chk("nob_rd2_pre", rd2_n, 32'h11111111);
    tick(); wr = 1'b0; #1;
    chk("nob_rd1_post", rd1_n, 32'h22222222);
    chk("nob_rd2_post", rd2_n, 32'h22222222);

    // Strobe held for several edges: last write wins.
    wr = 1'b1; wa = 5'd10; ra1 = 5'd10;
    wd = 32'h0000000A; tick();
    wd = 32'h0000000B; tick();
    wd = 32'h0000000C; tick();
    wr = 1'b0; #1;
    chk("last_wins", rd1_n, 32'h0000000C);

    // Reset mid-run.
    wr = 1'b1; wa = 5'd9; wd = 32'h55AA55AA; ra1 = 5'd9; tick(); wr = 1'b0; #1;
    chk("x9_written", rd1_b, 32'h55AA55AA);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("reset_drops_ready", {31'd0, rdy_b}, 32'd0);
    sweep_check("rerun_ready");
    #1 chk("x9_cleared", rd1_b, 32'd0);

    // Reset mid-sweep restarts from the beginning.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    sweep_check("restart_ready");
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
